// File: rtl/axis_word_packer.sv
// AXI-Stream width converter: packs DATA_WIDTH samples into PACK_FACTOR-lane words,
// flushing a zero-padded partial word when input_last is accepted.
module axis_word_packer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned PACK_FACTOR  = 4,
  parameter int unsigned OUTPUT_WIDTH = DATA_WIDTH * PACK_FACTOR,
  parameter int unsigned COUNT_WIDTH  = $clog2(PACK_FACTOR + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [DATA_WIDTH-1:0]   input_data,
  input  logic                    input_last,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [OUTPUT_WIDTH-1:0] output_data,
  output logic                    output_last,
  output logic [COUNT_WIDTH-1:0]  output_count
);

  localparam int unsigned CNT_W = (PACK_FACTOR > 1) ? $clog2(PACK_FACTOR) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_FACTOR - 1);

  logic [CNT_W-1:0]        cnt;
  logic [OUTPUT_WIDTH-1:0] acc;
  logic [OUTPUT_WIDTH-1:0] word_c;
  logic                    accept;
  logic                    complete;

  // Input is blocked only while a finished word waits on a stalled consumer.
  assign input_ready = !output_valid || output_ready;
  assign accept      = input_valid && input_ready;
  assign complete    = accept && ((cnt == LAST_LANE) || input_last);

  // Accumulator with the incoming sample dropped into lane cnt; higher lanes are still zero.
  always_comb begin
    word_c = acc;
    for (int unsigned k = 0; k < PACK_FACTOR; k++) begin
      if (CNT_W'(k) == cnt) begin
        word_c[k*DATA_WIDTH +: DATA_WIDTH] = input_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
      output_last  <= 1'b0;
      output_count <= '0;
    end else begin
      if (complete) begin
        output_data  <= word_c;
        output_count <= COUNT_WIDTH'(cnt) + COUNT_WIDTH'(1);
        output_last  <= input_last;
        output_valid <= 1'b1;
        cnt          <= '0;
        acc          <= '0;
      end else begin
        if (output_valid && output_ready) begin
          output_valid <= 1'b0;
        end
        if (accept) begin
          acc <= word_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
